// File: rtl/spi_slave_fifo.sv
// rtl/spi_slave_fifo.sv - oversampled SPI slave with show-ahead TX/RX FIFOs
// SCLK, CS_n and MOSI are sampled in the i_Clk domain; the SPI clock never clocks a flop.
module spi_slave_fifo #(
    parameter int SPI_MODE   = 0,
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_TX_Valid,
    input  logic [WORD_WIDTH-1:0]         i_TX_Data,
    output logic                          o_TX_Ready,
    output logic                          o_RX_Valid,
    output logic [WORD_WIDTH-1:0]         o_RX_Data,
    input  logic                          i_RX_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_TX_Count,
    output logic [$clog2(FIFO_DEPTH):0]   o_RX_Count,
    output logic                          o_TX_Underrun,
    output logic                          o_RX_Overrun,
    output logic                          o_Busy,
    input  logic                          i_SPI_Clk,
    input  logic                          i_SPI_MOSI,
    input  logic                          i_SPI_CS_n,
    output logic                          o_SPI_MISO
);
    localparam bit CPOL = ((SPI_MODE >> 1) & 1) != 0;
    localparam bit CPHA = (SPI_MODE & 1) != 0;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int BW   = $clog2(WORD_WIDTH);
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH - 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            sclk_q, cs_q;
    logic [1:0]            mosi_q;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WORD_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  underrun_q, overrun_q;

    logic [WORD_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]         tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    logic sclk_s, sclk_d, cs_s, mosi_s;
    logic lead_ev, trail_ev, sample_ev, shift_ev, cs_fall;
    logic load, word_done;
    logic tx_empty, tx_push, tx_pop, rx_push, rx_pop;
    logic [WORD_WIDTH-1:0] tx_head, rx_next, tx_adv;

    // Bit [1] is the synchroniser output, bit [2] the edge-detect delay.
    assign sclk_s = sclk_q[1];
    assign sclk_d = sclk_q[2];
    assign cs_s   = cs_q[1];
    assign mosi_s = mosi_q[1];

    assign lead_ev   = (sclk_d == CPOL) && (sclk_s != CPOL);
    assign trail_ev  = (sclk_d != CPOL) && (sclk_s == CPOL);
    assign sample_ev = CPHA ? trail_ev : lead_ev;
    assign shift_ev  = CPHA ? lead_ev : trail_ev;
    assign cs_fall   = cs_q[2] && !cs_q[1];

    assign rx_next = MSB_FIRST ? {rx_shift_q[WORD_WIDTH-2:0], mosi_s}
                               : {mosi_s, rx_shift_q[WORD_WIDTH-1:1]};
    assign tx_adv  = MSB_FIRST ? {tx_shift_q[WORD_WIDTH-2:0], 1'b0}
                               : {1'b0, tx_shift_q[WORD_WIDTH-1:1]};

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_head  = tx_empty ? '0 : tx_mem_q[tx_rd_q];
    assign tx_push  = i_TX_Valid && (tx_cnt_q != FULL);
    assign tx_pop   = load && !tx_empty;
    assign rx_pop   = i_RX_Ready && (rx_cnt_q != '0);
    // A full RX FIFO still accepts a word when the head is popped in the same cycle.
    assign rx_push  = word_done && ((rx_cnt_q != FULL) || rx_pop);
    assign tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    assign rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        load       = 1'b0;
        word_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (cs_fall) begin
                    state_d = ST_ACTIVE;
                    load    = !CPHA;
                end
            end
            ST_ACTIVE: begin
                if (cs_s) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else begin
                    if (sample_ev) begin
                        rx_shift_d = rx_next;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            word_done = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    // A shift edge at bit 0 starts a new word in both phases.
                    if (shift_ev) begin
                        if (bit_cnt_q == '0) begin
                            load = 1'b1;
                        end else begin
                            tx_shift_d = tx_adv;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            tx_shift_d = tx_head;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            sclk_q     <= {3{CPOL}};
            cs_q       <= 3'b111;
            mosi_q     <= '0;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= {sclk_q[1:0], i_SPI_Clk};
            cs_q       <= {cs_q[1:0], i_SPI_CS_n};
            mosi_q     <= {mosi_q[0], i_SPI_MOSI};
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            underrun_q <= load && tx_empty;
            overrun_q  <= word_done && !rx_push;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= i_TX_Data;
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_next;
    end

    assign o_TX_Ready    = (tx_cnt_q != FULL);
    assign o_RX_Valid    = (rx_cnt_q != '0);
    assign o_RX_Data     = (rx_cnt_q != '0) ? rx_mem_q[rx_rd_q] : '0;
    assign o_TX_Count    = tx_cnt_q;
    assign o_RX_Count    = rx_cnt_q;
    assign o_TX_Underrun = underrun_q;
    assign o_RX_Overrun  = overrun_q;
    assign o_Busy        = (state_q == ST_ACTIVE);
    assign o_SPI_MISO    = i_SPI_CS_n ? 1'bz
                         : (MSB_FIRST ? tx_shift_q[WORD_WIDTH-1] : tx_shift_q[0]);
endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb/tb_spi_slave_fifo.sv - randomized self-checking bench for spi_slave_fifo
// Instance 0: mode 0, 8-bit, MSB first. Instances 1..4: modes 0..3, 12-bit, LSB first.
module tb_spi_slave_fifo;
    localparam int HALF = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        tx_valid [5];
    logic [31:0] tx_data  [5];
    logic        rx_ready [5];
    logic        sclk [5], mosi [5], csn [5];
    wire         tx_ready [5], rx_valid [5], und [5], ovr [5], busy [5], miso [5];
    wire  [2:0]  tx_cnt [5], rx_cnt [5];
    wire  [31:0] rx_data [5];

    for (genvar k = 0; k < 5; k++) begin : g_dut
        localparam int W    = (k == 0) ? 8 : 12;
        localparam int MODE = (k == 0) ? 0 : k - 1;
        localparam bit MSB  = (k == 0);
        wire [W-1:0] d;
        wire         miso_w;
        pullup (miso_w);
        spi_slave_fifo #(.SPI_MODE(MODE), .WORD_WIDTH(W), .FIFO_DEPTH(4), .MSB_FIRST(MSB)) u_dut (
            .i_Clk(clk), .i_Rst_L(rst_n),
            .i_TX_Valid(tx_valid[k]), .i_TX_Data(tx_data[k][W-1:0]), .o_TX_Ready(tx_ready[k]),
            .o_RX_Valid(rx_valid[k]), .o_RX_Data(d), .i_RX_Ready(rx_ready[k]),
            .o_TX_Count(tx_cnt[k]), .o_RX_Count(rx_cnt[k]),
            .o_TX_Underrun(und[k]), .o_RX_Overrun(ovr[k]), .o_Busy(busy[k]),
            .i_SPI_Clk(sclk[k]), .i_SPI_MOSI(mosi[k]), .i_SPI_CS_n(csn[k]), .o_SPI_MISO(miso_w)
        );
        assign rx_data[k] = 32'(d);
        assign miso[k]    = miso_w;
    end

    int checks = 0;
    int errors = 0;

    int          und_n [5], ovr_n [5], vld_n [5], rx_n [5], wid_err [5];
    bit          und_p [5], ovr_p [5];
    logic [31:0] rx_log [5][32];

    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (und[k]) begin
                und_n[k]++;
                if (und_p[k]) wid_err[k]++;
            end
            if (ovr[k]) begin
                ovr_n[k]++;
                if (ovr_p[k]) wid_err[k]++;
            end
            und_p[k] = und[k];
            ovr_p[k] = ovr[k];
            if (rx_valid[k]) vld_n[k]++;
            if (rx_valid[k] && rx_ready[k]) begin
                rx_log[k][rx_n[k] % 32] = rx_data[k];
                rx_n[k]++;
            end
        end
    end

    // Reference model: TX queue consumed by word loads; empty queue yields zero plus underrun.
    logic [31:0] txm [$];
    int          exp_und = 0;
    logic [31:0] exp_miso [8];
    logic [31:0] m_out [8], m_in [8];

    function automatic logic [31:0] wmask(input int k);
        return (k == 0) ? 32'hFF : 32'hFFF;
    endfunction

    task automatic model_load(output logic [31:0] v);
        if (txm.size() > 0) begin
            v = txm.pop_front();
        end else begin
            v = 0;
            exp_und++;
        end
    endtask

    task automatic model_xfer(input int k, input int n, input int extra);
        int cpha, loads;
        cpha  = (k == 0) ? 0 : ((k - 1) & 1);
        loads = (cpha == 0) ? 1 + n : n + ((extra > 0) ? 1 : 0);
        for (int i = 0; i < loads; i++) model_load(exp_miso[i]);
    endtask

    task automatic push_tx(input int k, input logic [31:0] v);
        @(posedge clk); #1;
        tx_valid[k] = 1'b1;
        tx_data[k]  = v & wmask(k);
        @(posedge clk); #1;
        tx_valid[k] = 1'b0;
        txm.push_back(v & wmask(k));
    endtask

    task automatic spi_xfer(input int k, input int n, input int extra);
        int mode, w, total, wi, bi;
        bit msb, cpol, cpha;
        mode = (k == 0) ? 0 : k - 1;
        w    = (k == 0) ? 8 : 12;
        msb  = (k == 0);
        cpol = mode[1];
        cpha = mode[0];
        for (int i = 0; i < 8; i++) m_in[i] = 0;
        @(posedge clk); #1;
        sclk[k] = cpol;
        csn[k]  = 1'b0;
        #(HALF);
        total = n * w + extra;
        for (int b = 0; b < total; b++) begin
            wi = b / w;
            bi = msb ? (w - 1 - (b % w)) : (b % w);
            if (!cpha) begin
                mosi[k] = m_out[wi][bi];
                #(HALF);
                m_in[wi][bi] = miso[k];
                sclk[k] = ~cpol;
                #(HALF);
                sclk[k] = cpol;
            end else begin
                sclk[k] = ~cpol;
                mosi[k] = m_out[wi][bi];
                #(HALF);
                m_in[wi][bi] = miso[k];
                sclk[k] = cpol;
                #(HALF);
            end
        end
        #(HALF);
        csn[k] = 1'b1;
        #(2 * HALF);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({tx_ready[k], rx_valid[k], busy[k], und[k], ovr[k], tx_cnt[k], rx_cnt[k]} !== 11'b10000_000_000) begin
                errors++;
                $display("FAIL reset_flags inst %0d got %b exp %b", k,
                         {tx_ready[k], rx_valid[k], busy[k], und[k], ovr[k], tx_cnt[k], rx_cnt[k]}, 11'b10000_000_000);
            end
            checks++;
            if (rx_data[k] !== 0 || miso[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_data inst %0d rx_data %h miso %b exp 0 / 1", k, rx_data[k], miso[k]);
            end
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_basic;
        int u0, o0, v0, r0, e0;
        push_tx(0, 32'hA5);
        push_tx(0, 32'h00);
        m_out[0] = 32'h3C;
        u0 = und_n[0]; o0 = ovr_n[0]; v0 = vld_n[0]; r0 = rx_n[0]; e0 = exp_und;
        model_xfer(0, 1, 0);
        spi_xfer(0, 1, 0);
        checks++;
        if (m_in[0] !== 32'hA5 || exp_miso[0] !== 32'hA5) begin
            errors++; $display("FAIL basic_miso got %h exp %h", m_in[0], 32'hA5);
        end
        checks++;
        if (rx_n[0] - r0 != 1 || rx_log[0][r0 % 32] !== 32'h3C) begin
            errors++; $display("FAIL basic_rx count %0d word %h exp 1 / 3c", rx_n[0] - r0, rx_log[0][r0 % 32]);
        end
        checks++;
        if (vld_n[0] - v0 != 1) begin
            errors++; $display("FAIL basic_valid_cycles got %0d exp 1", vld_n[0] - v0);
        end
        checks++;
        if (und_n[0] - u0 != exp_und - e0 || ovr_n[0] - o0 != 0) begin
            errors++; $display("FAIL basic_pulses und %0d ovr %0d exp %0d / 0", und_n[0] - u0, ovr_n[0] - o0, exp_und - e0);
        end
        checks++;
        if (miso[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL basic_idle miso %b busy %b exp 1 / 0", miso[0], busy[0]);
        end
    endtask

    task automatic test_modes;
        int u0, r0, e0;
        for (int k = 1; k < 5; k++) begin
            push_tx(k, 32'hC3F);
            m_out[0] = 32'h5A3;
            u0 = und_n[k]; r0 = rx_n[k]; e0 = exp_und;
            model_xfer(k, 1, 0);
            spi_xfer(k, 1, 0);
            checks++;
            if (m_in[0] !== exp_miso[0]) begin
                errors++; $display("FAIL mode%0d_miso got %h exp %h", k - 1, m_in[0], exp_miso[0]);
            end
            checks++;
            if (rx_n[k] - r0 != 1 || rx_log[k][r0 % 32] !== 32'h5A3) begin
                errors++; $display("FAIL mode%0d_rx count %0d word %h exp 1 / 5a3", k - 1, rx_n[k] - r0, rx_log[k][r0 % 32]);
            end
            checks++;
            if (und_n[k] - u0 != exp_und - e0) begin
                errors++; $display("FAIL mode%0d_underrun got %0d exp %0d", k - 1, und_n[k] - u0, exp_und - e0);
            end
        end
    endtask

    task automatic test_burst;
        int u0, o0, r0, e0;
        for (int i = 0; i < 4; i++) push_tx(0, $urandom);
        for (int i = 0; i < 5; i++) m_out[i] = $urandom & 32'hFF;
        rx_ready[0] = 1'b0;
        u0 = und_n[0]; o0 = ovr_n[0]; r0 = rx_n[0]; e0 = exp_und;
        model_xfer(0, 5, 0);
        spi_xfer(0, 5, 0);
        checks++;
        if (ovr_n[0] - o0 != 1) begin
            errors++; $display("FAIL burst_overrun got %0d exp 1", ovr_n[0] - o0);
        end
        checks++;
        if (rx_cnt[0] !== 3'd4) begin
            errors++; $display("FAIL burst_rx_count got %0d exp 4", rx_cnt[0]);
        end
        checks++;
        if (und_n[0] - u0 != exp_und - e0) begin
            errors++; $display("FAIL burst_underrun got %0d exp %0d", und_n[0] - u0, exp_und - e0);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m_in[i] !== exp_miso[i]) begin
                errors++; $display("FAIL burst_miso%0d got %h exp %h", i, m_in[i], exp_miso[i]);
            end
        end
        @(posedge clk); #1;
        rx_ready[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (rx_n[0] - r0 != 4 || rx_cnt[0] !== 3'd0) begin
            errors++; $display("FAIL burst_drain popped %0d count %0d exp 4 / 0", rx_n[0] - r0, rx_cnt[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_log[0][(r0 + i) % 32] !== m_out[i]) begin
                errors++; $display("FAIL burst_rx%0d got %h exp %h", i, rx_log[0][(r0 + i) % 32], m_out[i]);
            end
        end
    endtask

    task automatic test_underrun;
        int u0, r0, e0, und_mid;
        logic [31:0] e_0, e_1, e_2;
        m_out[0] = $urandom & 32'hFF;
        m_out[1] = $urandom & 32'hFF;
        u0 = und_n[0]; r0 = rx_n[0]; e0 = exp_und;
        und_mid = 0;
        model_load(e_0);
        fork
            spi_xfer(0, 2, 0);
            begin
                repeat (30) @(posedge clk);
                und_mid = und_n[0] - u0;
                push_tx(0, 32'h81);
            end
        join
        model_load(e_1);
        model_load(e_2);
        checks++;
        if (m_in[0] !== 32'h00 || m_in[0] !== e_0) begin
            errors++; $display("FAIL underrun_word0 got %h exp 00", m_in[0]);
        end
        checks++;
        if (und_mid != 1) begin
            errors++; $display("FAIL underrun_first_pulse got %0d exp 1", und_mid);
        end
        checks++;
        if (m_in[1] !== 32'h81 || m_in[1] !== e_1) begin
            errors++; $display("FAIL underrun_word1 got %h exp 81", m_in[1]);
        end
        checks++;
        if (und_n[0] - u0 != exp_und - e0) begin
            errors++; $display("FAIL underrun_total got %0d exp %0d", und_n[0] - u0, exp_und - e0);
        end
        checks++;
        if (rx_n[0] - r0 != 2 || rx_log[0][(r0 + 1) % 32] !== m_out[1]) begin
            errors++; $display("FAIL underrun_rx count %0d word %h exp 2 / %h", rx_n[0] - r0, rx_log[0][(r0 + 1) % 32], m_out[1]);
        end
    endtask

    task automatic test_cs_abort;
        int r0;
        push_tx(0, $urandom);
        push_tx(0, $urandom);
        m_out[0] = $urandom & 32'hFF;
        r0 = rx_n[0];
        model_xfer(0, 0, 5);
        spi_xfer(0, 0, 5);
        checks++;
        if (rx_n[0] != r0 || rx_valid[0] !== 1'b0) begin
            errors++; $display("FAIL abort_no_rx got %0d words exp 0", rx_n[0] - r0);
        end
        checks++;
        if (miso[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL abort_miso_z miso %b busy %b exp 1 / 0", miso[0], busy[0]);
        end
        m_out[0] = 32'h96;
        model_xfer(0, 1, 0);
        spi_xfer(0, 1, 0);
        checks++;
        if (rx_n[0] - r0 != 1 || rx_log[0][r0 % 32] !== 32'h96) begin
            errors++; $display("FAIL abort_rx count %0d word %h exp 1 / 96", rx_n[0] - r0, rx_log[0][r0 % 32]);
        end
        checks++;
        if (m_in[0] !== exp_miso[0]) begin
            errors++; $display("FAIL abort_miso got %h exp %h", m_in[0], exp_miso[0]);
        end
    endtask

    task automatic test_reset_midburst;
        for (int i = 0; i < 3; i++) push_tx(0, $urandom);
        for (int i = 0; i < 3; i++) m_out[i] = $urandom & 32'hFF;
        fork
            spi_xfer(0, 3, 0);
            begin
                repeat (40) @(posedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                checks++;
                if ({tx_ready[0], rx_valid[0], busy[0], und[0], ovr[0], tx_cnt[0], rx_cnt[0]} !== 11'b10000_000_000) begin
                    errors++;
                    $display("FAIL midreset_flags got %b exp %b",
                             {tx_ready[0], rx_valid[0], busy[0], und[0], ovr[0], tx_cnt[0], rx_cnt[0]}, 11'b10000_000_000);
                end
                checks++;
                if (rx_data[0] !== 0) begin
                    errors++; $display("FAIL midreset_rx_data got %h exp 0", rx_data[0]);
                end
            end
        join
        txm.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tx_cnt[0] !== 3'd0 || miso[0] !== 1'b1) begin
            errors++; $display("FAIL midreset_after count %0d miso %b exp 0 / 1", tx_cnt[0], miso[0]);
        end
    endtask

    task automatic test_random;
        int n, npre, u0, o0, r0, e0;
        for (int it = 0; it < 6; it++) begin
            npre = $urandom_range(4 - txm.size(), 0);
            for (int i = 0; i < npre; i++) push_tx(0, $urandom);
            n = $urandom_range(3, 1);
            for (int i = 0; i < n; i++) m_out[i] = $urandom & 32'hFF;
            u0 = und_n[0]; o0 = ovr_n[0]; r0 = rx_n[0]; e0 = exp_und;
            model_xfer(0, n, 0);
            spi_xfer(0, n, 0);
            for (int i = 0; i < n; i++) begin
                checks++;
                if (m_in[i] !== exp_miso[i]) begin
                    errors++; $display("FAIL rand%0d_miso%0d got %h exp %h", it, i, m_in[i], exp_miso[i]);
                end
                checks++;
                if (rx_log[0][(r0 + i) % 32] !== m_out[i]) begin
                    errors++; $display("FAIL rand%0d_rx%0d got %h exp %h", it, i, rx_log[0][(r0 + i) % 32], m_out[i]);
                end
            end
            checks++;
            if (rx_n[0] - r0 != n || und_n[0] - u0 != exp_und - e0 || ovr_n[0] != o0) begin
                errors++;
                $display("FAIL rand%0d_counts rx %0d und %0d ovr %0d exp %0d / %0d / 0",
                         it, rx_n[0] - r0, und_n[0] - u0, ovr_n[0] - o0, n, exp_und - e0);
            end
            checks++;
            if (tx_cnt[0] !== 3'(txm.size())) begin
                errors++; $display("FAIL rand%0d_tx_count got %0d exp %0d", it, tx_cnt[0], txm.size());
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = 0;
            rx_ready[k] = 1'b1;
            mosi[k]     = 1'b0;
            csn[k]      = 1'b1;
            sclk[k]     = (k >= 3);
        end
        test_reset();
        test_basic();
        test_modes();
        test_burst();
        test_underrun();
        test_cs_abort();
        test_reset_midburst();
        test_random();
        checks++;
        if (wid_err[0] + wid_err[1] + wid_err[2] + wid_err[3] + wid_err[4] != 0) begin
            errors++;
            $display("FAIL pulse_width wide pulses %0d exp 0",
                     wid_err[0] + wid_err[1] + wid_err[2] + wid_err[3] + wid_err[4]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_fifo.md
# spi_slave_fifo

Parametrised, fully synchronous SPI slave for the FPGA fabric side of the SPI bus. It oversamples SCLK, CS_n and MOSI in the single system clock domain, so the SPI clock never drives a flop. It supports configurable mode, word width and bit order, with show-ahead TX and RX FIFOs behind ready/valid handshakes. It adds back-to-back multi-word bursts without per-word host intervention, plus underrun and overrun reporting.

## Interface
- SPI_MODE, 0: SPI mode 0–3. CPOL = mode[1], CPHA = mode[0].
- WORD_WIDTH, 8: bits per SPI word, 4–32.
- FIFO_DEPTH, 4: entries per FIFO. Power of two, ≥2.
- MSB_FIRST, 1: 1 = MSB shifted first on both lines; 0 = LSB first.
- i_Clk  in  1  system clock. Must be ≥8× the SCLK frequency.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_TX_Valid  in  1  TX write request.
- i_TX_Data  in  WORD_WIDTH  word to send on MISO.
- o_TX_Ready  out  1  TX FIFO not full.
- o_RX_Valid  out  1  RX FIFO not empty; o_RX_Data holds the head entry.
- o_RX_Data  out  WORD_WIDTH  received word.
- i_RX_Ready  in  1  pop RX head when o_RX_Valid=1.
- o_TX_Count / o_RX_Count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_TX_Underrun  out  1  one-cycle pulse.
- o_RX_Overrun  out  1  one-cycle pulse.
- o_Busy  out  1  synchronised CS active.
- i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n  in  1  SPI pins, asynchronous to i_Clk.
- o_SPI_MISO  out  1  Z whenever raw i_SPI_CS_n=1.

## Operation
- **Synchronisers:** 2-flop synchronisers on SCLK, MOSI and CS_n, followed by one delay flop for edge detection.
  - Leading edge = synchronised SCLK leaving CPOL level. Trailing edge = returning to it.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
- **States:**
  - IDLE (sync CS high) → ACTIVE on sync CS falling.
  - ACTIVE → IDLE on sync CS rising, from any bit position.
- **Receive path:** each sample edge shifts MOSI into the RX shift register and increments bit_cnt. When bit_cnt reaches WORD_WIDTH:
  - bit_cnt wraps to 0.
  - The word is pushed to the RX FIFO if not full.
  - If the FIFO is full, the word is dropped and o_RX_Overrun pulses.
- **Word load, CPHA=0:** occurs at sync CS falling, and at the shift edge following each completed word.
- **Word load, CPHA=1:** occurs at the first leading edge of each word (bit_cnt=0).
- **Word load action:** pop the TX FIFO head if one is present. If the FIFO is empty, load all-zeros and pulse o_TX_Underrun.
- **MISO:** other shift edges advance the TX shift register one bit. o_SPI_MISO presents the current first-order bit (MSB or LSB per MSB_FIRST).
- **CS deassert mid-word:**
  - The partial RX word is discarded and never pushed.
  - The already-popped TX word is lost.
  - bit_cnt is cleared.
- **FIFOs:** show-ahead.
  - A push when full is ignored.
  - A pop when empty is ignored.
  - RX push and pop in the same cycle while full both succeed, with no overrun.
  - TX push and load in the same cycle while empty counts as underrun (no bypass); the pushed word stays queued for the next word.
- **Reset:**
  - FIFOs empty, all counters and state cleared (IDLE).
  - o_RX_Valid=0, o_RX_Data=0.
  - o_TX_Ready=1, both counts 0.
  - Both pulse outputs 0, o_Busy=0.
  - o_SPI_MISO per CS (Z when CS high).

## Timing
- **Pin-edge detection:** 3 i_Clk after the pin transition.
- **RX latency:** o_RX_Valid rises 1 i_Clk after the detected final sample edge, i.e. ≤4 i_Clk after the pin edge.
- **MISO update:** registered bit changes 1 i_Clk after the detected shift or load event (≤4 i_Clk after the pin edge). This is why SCLK half-period must be ≥4 i_Clk.
- **TX pop timing:** a TX word written ≥1 i_Clk before its load event is used.
- **Counts:** o_TX_Ready and counts are registered, updating the cycle after push/pop.
- **Pulses:** o_RX_Overrun and o_TX_Underrun are exactly 1 i_Clk wide, one per affected word.
- **Bursts:** words are back-to-back with no dead bit between them while CS is held low.

## Test plan
- **Mode 0, 8-bit, MSB first.** Preload TX 0xA5; master sends 0x3C. Required: master reads 0xA5; o_RX_Data=0x3C with a 1-cycle o_RX_Valid; no pulses.
- **All four modes, WORD_WIDTH=12, MSB_FIRST=0.** Master exchanges 0x5A3 ↔ 0xC3F with 1 word per CS. Required: bit-exact in both directions, LSB first.
- **Burst of 5 words, FIFO_DEPTH=4, i_RX_Ready=0.** Required: RX holds words 1–4; o_RX_Overrun pulses once at word 5; o_RX_Count=4.
- **TX empty at CS fall.** Required: master reads 0x00; o_TX_Underrun pulses once. Then push 0x81 mid-word; the next word returns 0x81.
- **CS raised after 5 bits, then a new 8-bit transfer of 0x96.** Required: only 0x96 is received; o_SPI_MISO is Z while CS is high.
- **i_Rst_L asserted mid-burst.** Required: all outputs go to reset values immediately; FIFOs empty; the next transfer works normally.
